// File: rtl/wbs_ctrl_if.sv
// Wishbone slave bus bundle for wbs_ctrl: the master drives the request, the slave returns ack/data.
interface wbs_ctrl_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/wbs_ctrl.sv
// Wishbone slave into the accelerator config regs, query SRAM, leaf banks and node memory.
// Define WBS_UNMAPPED_ACK_EN to ack unmapped addresses with zero data instead of ignoring them.
module wbs_ctrl #(
   parameter int  DATA_WIDTH = 11,
   parameter int  LEAF_SIZE  = 8,
   parameter int  PATCH_SIZE = 5,
   parameter int  ROW_SIZE   = 24,
   parameter int  COL_SIZE   = 17,
   parameter int  K          = 4,
   parameter int  NUM_LEAVES = 64,
   localparam int PW         = PATCH_SIZE * DATA_WIDTH,
   localparam int NUM_QUERYS = ROW_SIZE * COL_SIZE,
   localparam int QW         = $clog2(NUM_QUERYS),
   localparam int LEAF_ADDRW = $clog2(NUM_LEAVES)
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   wbs_ctrl_if.slave             wbs,
   output logic                  wbs_mode,
   output logic                  wbs_debug,
   output logic                  wbs_qp_mem_csb0,
   output logic                  wbs_qp_mem_web0,
   output logic [QW-1:0]         wbs_qp_mem_addr0,
   output logic [PW-1:0]         wbs_qp_mem_wpatch0,
   input  logic [PW-1:0]         wbs_qp_mem_rpatch0,
   output logic [LEAF_SIZE-1:0]  wbs_leaf_mem_csb0,
   output logic [LEAF_SIZE-1:0]  wbs_leaf_mem_web0,
   output logic [LEAF_ADDRW-1:0] wbs_leaf_mem_addr0,
   output logic [63:0]           wbs_leaf_mem_wleaf0,
   input  logic [63:0]           wbs_leaf_mem_rleaf0 [LEAF_SIZE],
   output logic                  wbs_node_mem_web,
   output logic [31:0]           wbs_node_mem_addr,
   output logic [31:0]           wbs_node_mem_wdata,
   input  logic [31:0]           wbs_node_mem_rdata
);

   typedef enum logic [2:0] {S_IDLE, S_RD1, S_RD2, S_WR, S_ACK} state_t;

   state_t      state_q, state_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] wdat_q, wdat_d;
   logic [31:0] hold_q, hold_d;
   logic [31:0] dat_q, dat_d;
   logic        we_q, we_d;
   logic        mode_q, mode_d;
   logic        debug_q, debug_d;

   logic        is_q, is_l, is_n, mem_act, mem_wr;
   logic [2:0]  bank;
   logic [63:0] wide;
   logic        sel_unused;
   logic [K-1:0] best_unused;

   assign sel_unused  = ^wbs.wbs_sel_i;
   assign best_unused = '0;

   assign is_q    = (adr_q[31:24] == 8'h31);
   assign is_l    = (adr_q[31:24] == 8'h32);
   assign is_n    = (adr_q[31:24] == 8'h34);
   assign bank    = adr_q[3:1];
   assign mem_act = (state_q == S_RD1) || (state_q == S_WR);
   assign mem_wr  = (state_q == S_WR);
   // Upper-half write merges the new word with the previously held lower word.
   assign wide    = {wdat_q, hold_q};

   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      wdat_d  = wdat_q;
      we_d    = we_q;
      hold_d  = hold_q;
      dat_d   = dat_q;
      mode_d  = mode_q;
      debug_d = debug_q;
      case (state_q)
         S_IDLE: begin
            if (wbs.wbs_cyc_i && wbs.wbs_stb_i && !wbs.wbs_ack_o) begin
               adr_d  = wbs.wbs_adr_i;
               wdat_d = wbs.wbs_dat_i;
               we_d   = wbs.wbs_we_i;
               dat_d  = '0;
               case (wbs.wbs_adr_i[31:24])
                  8'h30: begin
                     state_d = S_ACK;
                     if (wbs.wbs_we_i) begin
                        if (wbs.wbs_adr_i == 32'h3000_0000) mode_d  = wbs.wbs_dat_i[0];
                        if (wbs.wbs_adr_i == 32'h3000_0001) debug_d = wbs.wbs_dat_i[0];
                     end else if (wbs.wbs_adr_i == 32'h3000_0000) begin
                        dat_d = {31'b0, mode_q};
                     end else if (wbs.wbs_adr_i == 32'h3000_0001) begin
                        dat_d = {31'b0, debug_q};
                     end
                  end
                  8'h31, 8'h32: begin
                     if (!wbs.wbs_we_i) begin
                        state_d = S_RD1;
                     end else if (!wbs.wbs_adr_i[0]) begin
                        hold_d  = wbs.wbs_dat_i;
                        state_d = S_ACK;
                     end else begin
                        state_d = S_WR;
                     end
                  end
                  8'h33:   state_d = S_ACK;
                  8'h34:   state_d = wbs.wbs_we_i ? S_ACK : S_RD2;
`ifdef WBS_UNMAPPED_ACK_EN
                  default: state_d = S_ACK;
`else
                  default: state_d = S_IDLE;
`endif
               endcase
            end
         end
         S_RD1: state_d = S_RD2;
         S_RD2: begin
            state_d = S_ACK;
            if (is_q)      dat_d = adr_q[0] ? 32'(wbs_qp_mem_rpatch0[PW-1:32]) : wbs_qp_mem_rpatch0[31:0];
            else if (is_l) dat_d = adr_q[0] ? wbs_leaf_mem_rleaf0[bank][63:32] : wbs_leaf_mem_rleaf0[bank][31:0];
            else           dat_d = wbs_node_mem_rdata;
         end
         S_WR:    state_d = S_ACK;
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= S_IDLE;
         adr_q   <= '0;
         wdat_q  <= '0;
         we_q    <= 1'b0;
         hold_q  <= '0;
         dat_q   <= '0;
         mode_q  <= 1'b0;
         debug_q <= 1'b0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
         we_q    <= we_d;
         hold_q  <= hold_d;
         dat_q   <= dat_d;
         mode_q  <= mode_d;
         debug_q <= debug_d;
      end
   end

   assign wbs.wbs_ack_o = (state_q == S_ACK);
   assign wbs.wbs_dat_o = dat_q;
   assign wbs_mode      = mode_q;
   assign wbs_debug     = debug_q;

   assign wbs_qp_mem_csb0    = ~(mem_act && is_q);
   assign wbs_qp_mem_web0    = ~(mem_wr && is_q);
   assign wbs_qp_mem_addr0   = adr_q[QW:1];
   assign wbs_qp_mem_wpatch0 = wide[PW-1:0];

   always_comb begin
      wbs_leaf_mem_csb0 = '1;
      wbs_leaf_mem_web0 = '1;
      for (int b = 0; b < LEAF_SIZE; b++) begin
         if (is_l && int'(bank) == b) begin
            wbs_leaf_mem_csb0[b] = ~mem_act;
            wbs_leaf_mem_web0[b] = ~mem_wr;
         end
      end
   end

   assign wbs_leaf_mem_addr0  = adr_q[4 +: LEAF_ADDRW];
   assign wbs_leaf_mem_wleaf0 = wide;

   assign wbs_node_mem_web   = (state_q != S_IDLE) && is_n && we_q;
   assign wbs_node_mem_addr  = adr_q;
   assign wbs_node_mem_wdata = wdat_q;

endmodule

// File: tb/tb_wbs_ctrl.sv
// Randomized bench for wbs_ctrl: bus transactions checked against a shadow model of regs and memories.
module tb_wbs_ctrl;
   localparam int PW = 55;
   localparam int QW = 9;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        wbs_mode, wbs_debug;
   logic        qp_csb, qp_web;
   logic [QW-1:0] qp_addr;
   logic [PW-1:0] qp_wpatch, qp_rpatch;
   logic [7:0]  leaf_csb, leaf_web;
   logic [5:0]  leaf_addr;
   logic [63:0] leaf_wleaf;
   logic [63:0] rleaf [8];
   logic        node_web;
   logic [31:0] node_addr, node_wdata, node_rdata;

   wbs_ctrl_if bus ();

   wbs_ctrl dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wbs(bus),
      .wbs_mode(wbs_mode), .wbs_debug(wbs_debug),
      .wbs_qp_mem_csb0(qp_csb), .wbs_qp_mem_web0(qp_web), .wbs_qp_mem_addr0(qp_addr),
      .wbs_qp_mem_wpatch0(qp_wpatch), .wbs_qp_mem_rpatch0(qp_rpatch),
      .wbs_leaf_mem_csb0(leaf_csb), .wbs_leaf_mem_web0(leaf_web), .wbs_leaf_mem_addr0(leaf_addr),
      .wbs_leaf_mem_wleaf0(leaf_wleaf), .wbs_leaf_mem_rleaf0(rleaf),
      .wbs_node_mem_web(node_web), .wbs_node_mem_addr(node_addr),
      .wbs_node_mem_wdata(node_wdata), .wbs_node_mem_rdata(node_rdata)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // SRAM models with one-cycle read latency plus activity counters
   logic [PW-1:0] qmem [512];
   logic [63:0]   lmem [8][64];
   int q_rd_n = 0, q_wr_n = 0, l_rd_n = 0, l_wr_n = 0, l_multi_n = 0, node_wr_n = 0;
   int l_last_b = 0;
   logic [QW-1:0] q_last_wa = '0;
   logic [PW-1:0] q_last_wd = '0;
   logic [5:0]    l_last_a = '0;
   logic [63:0]   l_last_wd = '0;
   logic [31:0]   node_last_a = '0, node_last_d = '0;

   always @(posedge wb_clk_i) begin
      if (!qp_csb) begin
         if (!qp_web) begin
            qmem[qp_addr] <= qp_wpatch;
            q_wr_n <= q_wr_n + 1;
            q_last_wa <= qp_addr;
            q_last_wd <= qp_wpatch;
         end else begin
            qp_rpatch <= qmem[qp_addr];
            q_rd_n <= q_rd_n + 1;
         end
      end
      if ($countones(~leaf_csb) > 1) l_multi_n <= l_multi_n + 1;
      for (int b = 0; b < 8; b++) begin
         if (!leaf_csb[b]) begin
            l_last_b <= b;
            l_last_a <= leaf_addr;
            if (!leaf_web[b]) begin
               lmem[b][leaf_addr] <= leaf_wleaf;
               l_wr_n <= l_wr_n + 1;
               l_last_wd <= leaf_wleaf;
            end else begin
               rleaf[b] <= lmem[b][leaf_addr];
               l_rd_n <= l_rd_n + 1;
            end
         end
      end
      if (node_web) begin
         node_wr_n <= node_wr_n + 1;
         node_last_a <= node_addr;
         node_last_d <= node_wdata;
      end
   end

   // Reference model state
   logic [PW-1:0] exp_q [512];
   logic [63:0]   exp_l [8][64];
   logic [31:0]   exp_hold = '0;
   logic          exp_mode = 1'b0, exp_debug = 1'b0;
   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Cycles from request presentation to visible ack; 0 = never acked
   function automatic int exp_lat(input logic we, input logic [31:0] adr);
      case (adr[31:24])
         8'h30, 8'h33: return 1;
         8'h31, 8'h32: return we ? (adr[0] ? 2 : 1) : 3;
         8'h34:        return we ? 1 : 2;
`ifdef WBS_UNMAPPED_ACK_EN
         default:      return 1;
`else
         default:      return 0;
`endif
      endcase
   endfunction

   task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       output logic [31:0] rd, output int cyc, output logic acked);
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
      bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = 4'hf;
      cyc = 0; acked = 1'b0; rd = '0;
      while (cyc < 10 && !acked) begin
         @(posedge wb_clk_i); cyc++;
         @(negedge wb_clk_i);
         if (bus.wbs_ack_o) begin acked = 1'b1; rd = bus.wbs_dat_o; end
      end
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
      @(posedge wb_clk_i); #1;
   endtask

   task automatic do_wr(input logic [31:0] adr, input logic [31:0] dat);
      logic [31:0] rd; int cyc; logic acked; int lat;
      int qw0, lw0, nw0;
      logic [8:0] a; logic [2:0] bk; logic [5:0] row;
      a = adr[9:1]; bk = adr[3:1]; row = adr[9:4];
      lat = exp_lat(1'b1, adr);
      qw0 = q_wr_n; lw0 = l_wr_n; nw0 = node_wr_n;
      xfer(1'b1, adr, dat, rd, cyc, acked);
      chk("wr_acked", acked, lat != 0);
      if (lat != 0) chk("wr_lat", cyc, lat);
      chk("ack_pulse", bus.wbs_ack_o, 0);
      case (adr[31:24])
         8'h30: begin
            if (adr == 32'h3000_0000) exp_mode  = dat[0];
            if (adr == 32'h3000_0001) exp_debug = dat[0];
            chk("mode", wbs_mode, exp_mode);
            chk("debug", wbs_debug, exp_debug);
         end
         8'h31: begin
            if (!adr[0]) begin
               exp_hold = dat;
               chk("q_lo_nowr", q_wr_n - qw0, 0);
            end else begin
               exp_q[a] = PW'({dat, exp_hold});
               chk("q_wr_cnt", q_wr_n - qw0, 1);
               chk("q_wr_addr", q_last_wa, a);
               chk("q_wr_data", q_last_wd, exp_q[a]);
            end
         end
         8'h32: begin
            if (!adr[0]) begin
               exp_hold = dat;
               chk("l_lo_nowr", l_wr_n - lw0, 0);
            end else begin
               exp_l[bk][row] = {dat, exp_hold};
               chk("l_wr_cnt", l_wr_n - lw0, 1);
               chk("l_wr_bank", l_last_b, bk);
               chk("l_wr_row", l_last_a, row);
               chk("l_wr_data", l_last_wd, exp_l[bk][row]);
            end
         end
         8'h34: begin
            chk("n_wr_cnt", node_wr_n - nw0, 1);
            chk("n_wr_addr", node_last_a, adr);
            chk("n_wr_data", node_last_d, dat);
         end
         default: chk("no_mem_wr", (q_wr_n - qw0) + (l_wr_n - lw0) + (node_wr_n - nw0), 0);
      endcase
   endtask

   task automatic do_rd(input logic [31:0] adr);
      logic [31:0] rd, exp; int cyc; logic acked; int lat;
      int qr0, lr0, lm0, nw0;
      logic [8:0] a; logic [2:0] bk; logic [5:0] row;
      a = adr[9:1]; bk = adr[3:1]; row = adr[9:4];
      lat = exp_lat(1'b0, adr);
      exp = '0;
      case (adr[31:24])
         8'h30: exp = (adr == 32'h3000_0000) ? {31'b0, exp_mode} :
                      (adr == 32'h3000_0001) ? {31'b0, exp_debug} : 32'h0;
         8'h31: exp = adr[0] ? 32'(exp_q[a] >> 32) : exp_q[a][31:0];
         8'h32: exp = adr[0] ? exp_l[bk][row][63:32] : exp_l[bk][row][31:0];
         8'h34: begin node_rdata = $urandom; exp = node_rdata; end
         default: exp = '0;
      endcase
      qr0 = q_rd_n; lr0 = l_rd_n; lm0 = l_multi_n; nw0 = node_wr_n;
      xfer(1'b0, adr, 32'h0, rd, cyc, acked);
      chk("rd_acked", acked, lat != 0);
      if (acked) chk("rd_data", rd, exp);
      if (lat != 0) chk("rd_lat", cyc, lat);
      chk("ack_pulse", bus.wbs_ack_o, 0);
      if (adr[31:24] == 8'h31) chk("q_rd_cnt", q_rd_n - qr0, 1);
      if (adr[31:24] == 8'h32) begin
         chk("l_rd_cnt", l_rd_n - lr0, 1);
         chk("l_one_bank", l_multi_n - lm0, 0);
         chk("l_rd_bank", l_last_b, bk);
      end
      if (adr[31:24] == 8'h34) chk("n_rd_nowr", node_wr_n - nw0, 0);
   endtask

   function automatic logic [31:0] q_adr(input int a, input int half);
      return 32'h3100_0000 | 32'(a << 1) | 32'(half);
   endfunction

   function automatic logic [31:0] l_adr(input int bk, input int row, input int half);
      return 32'h3200_0000 | 32'(row << 4) | 32'(bk << 1) | 32'(half);
   endfunction

   initial begin
      logic [31:0] rd; int cyc; logic acked, seen;
      bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
      bus.wbs_sel_i = 0; bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
      node_rdata = '0;
      repeat (3) @(posedge wb_clk_i);
      #1;
      chk("rst_ack", bus.wbs_ack_o, 0);
      chk("rst_dat", bus.wbs_dat_o, 0);
      chk("rst_mode", wbs_mode, 0);
      chk("rst_debug", wbs_debug, 0);
      chk("rst_q_csb", {qp_csb, qp_web}, 2'b11);
      chk("rst_l_csb", {leaf_csb, leaf_web}, 16'hffff);
      chk("rst_n_web", node_web, 0);
      wb_rst_i = 1'b0;
      @(posedge wb_clk_i); #1;

      do_wr(32'h3000_0001, 32'h1);
      do_wr(32'h3000_0000, 32'h1);
      do_wr(32'h3000_0001, 32'h0);
      do_rd(32'h3000_0000);
      do_rd(32'h3000_0001);

      do_wr(32'h3100_0002, 32'hDEAD_BEEF);
      do_wr(32'h3100_0003, 32'h0000_1010);
      chk("q_patch1", qmem[1], 55'h00_1010_DEAD_BEEF);
      do_rd(32'h3100_0002);
      do_rd(32'h3100_0003);
      do_wr(32'h3100_0004, 32'h0123_4567);
      do_wr(32'h3100_0005, 32'h000B_CDEF);
      chk("q_patch2", q_last_wd, 55'h0BCDEF_01234567);

      do_wr(32'h3200_000E, 32'hDEAD_BEEF);
      do_wr(32'h3200_000F, 32'h1100_1010);
      do_rd(32'h3200_000E);
      do_rd(32'h3200_000F);
      do_wr(32'h3200_0006, 32'h7654_3210);
      do_wr(32'h3200_0007, 32'hFEDC_BA98);
      chk("l_wleaf", l_last_wd, 64'hFEDCBA98_76543210);

      do_wr(32'h3400_0001, {10'd0, 11'd55, 11'd1});
      do_rd(32'h3400_0001);
      do_rd(32'h3300_0000);
      do_wr(32'h3300_0000, 32'hFFFF_FFFF);

      xfer(1'b0, 32'h3500_0000, 32'h0, rd, cyc, acked);
`ifdef WBS_UNMAPPED_ACK_EN
      chk("unmapped_ack", acked, 1);
      chk("unmapped_dat", rd, 0);
`else
      chk("unmapped_noack", acked, 0);
`endif

      // Fill the random-phase address pools so every read targets known data
      for (int a = 0; a < 8; a++) begin
         do_wr(q_adr(a, 0), $urandom);
         do_wr(q_adr(a, 1), $urandom);
      end
      for (int bk = 0; bk < 8; bk++)
         for (int row = 0; row < 4; row++) begin
            do_wr(l_adr(bk, row, 0), $urandom);
            do_wr(l_adr(bk, row, 1), $urandom);
         end

      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 7))
            0: do_wr(32'h3000_0000 | 32'($urandom_range(0, 2)), $urandom);
            1: do_rd(32'h3000_0000 | 32'($urandom_range(0, 2)));
            2: begin
               int a; a = $urandom_range(0, 7);
               do_wr(q_adr(a, 0), $urandom);
               do_wr(q_adr(a, 1), $urandom);
            end
            3: do_rd(q_adr($urandom_range(0, 7), $urandom_range(0, 1)));
            4: begin
               int bk, row; bk = $urandom_range(0, 7); row = $urandom_range(0, 3);
               do_wr(l_adr(bk, row, 0), $urandom);
               do_wr(l_adr(bk, row, 1), $urandom);
            end
            5: do_rd(l_adr($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 1)));
            6: begin
               if ($urandom_range(0, 1) == 1) do_wr(32'h3400_0000 | 32'($urandom_range(0, 65535)), $urandom);
               else                           do_rd(32'h3400_0000 | 32'($urandom_range(0, 65535)));
            end
            default: begin
               if ($urandom_range(0, 1) == 1) do_wr(q_adr($urandom_range(0, 7), 1), $urandom);
               else                           do_wr(32'h3300_0000 | 32'($urandom_range(0, 255)), $urandom);
            end
         endcase
      end

      // Strobe dropped mid-access: bus must recover and serve the next read
      do_wr(32'h3000_0000, 32'h1);
      bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = q_adr(2, 0);
      @(posedge wb_clk_i); #1;
      bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
      repeat (6) @(posedge wb_clk_i);
      #1;
      do_rd(q_adr(3, 0));

      // Reset during a memory read aborts it without an ack
      bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = q_adr(1, 0);
      @(posedge wb_clk_i); #1;
      @(posedge wb_clk_i); #1;
      wb_rst_i = 1'b1;
      #1;
      chk("rst_mid_ack", bus.wbs_ack_o, 0);
      chk("rst_mid_csb", qp_csb, 1);
      chk("rst_mid_mode", wbs_mode, 0);
      bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge wb_clk_i);
         if (bus.wbs_ack_o) seen = 1'b1;
      end
      chk("rst_mid_noack", seen, 0);
      @(posedge wb_clk_i); #1;
      wb_rst_i = 1'b0;
      exp_mode = 1'b0; exp_debug = 1'b0; exp_hold = '0;
      @(posedge wb_clk_i); #1;
      do_rd(32'h3000_0000);
      do_wr(q_adr(4, 1), 32'h0000_0ABC);
      do_rd(q_adr(4, 0));
      do_rd(q_adr(4, 1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
